// File: rtl/stream_dispatch_scheduler.sv
// stream_dispatch_scheduler
// Credit-based round-robin scheduler that produces the per-packet select
// stream for the data demultiplexer. Each output stream owns a pool of
// MAX_CREDITS credits. A dispatch (select handshake) consumes one credit and a
// downstream credit_return pulse gives one back. Only streams that still have
// a free credit are offered, and the search for the next one starts just
// after the most recently granted stream.
//
// Optional feature macro: STREAM_DISPATCH_STATS_EN
//   When defined, the block adds the dispatch_count output, which holds one
//   free-running 32-bit handshake counter per stream.
`timescale 1ns/1ps

module stream_dispatch_scheduler #(
    parameter int NUM_STREAMS = 4,
    parameter int MAX_CREDITS = 8
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                enable,
    output logic                                                select_valid,
    input  logic                                                select_ready,
    output logic [$clog2(NUM_STREAMS)-1:0]                      select_data,
    input  logic [NUM_STREAMS-1:0]                              credit_return,
    output logic [NUM_STREAMS*$clog2(MAX_CREDITS+1)-1:0]        credits,
    output logic                                                all_idle,
    output logic                                                credit_overflow
`ifdef STREAM_DISPATCH_STATS_EN
    ,
    output logic [NUM_STREAMS*32-1:0]                           dispatch_count
`endif
);

    localparam int PW = $clog2(NUM_STREAMS);
    localparam int CW = $clog2(MAX_CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(MAX_CREDITS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [PW-1:0]          data_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]          cred_q [NUM_STREAMS];
    logic [CW-1:0]          cred_d [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] dec_vec;
    logic [NUM_STREAMS-1:0] ovf_hit;
    logic [NUM_STREAMS-1:0] eligible;
    logic [NUM_STREAMS-1:0] at_max_d;
    logic [PW-1:0]          choice;
    logic [PW-1:0]          idx;
    logic                   handshake;
    logic                   any_elig;

    assign handshake    = select_valid && select_ready;
    assign select_valid = (state_q == ST_OFFER);
    assign any_elig     = |eligible;

    // Decode which stream (if any) is consuming a credit this cycle.
    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_vec = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            dec_vec[i] = handshake && (select_data == PW'(i));
        end
    end

    // Next credit count per stream: -1 on dispatch, +1 on return, saturating
    // at MAX_CREDITS. A return that arrives while the stream is already full
    // is flagged as an overflow.
    always_comb begin
        ovf_hit  = '0;
        eligible = '0;
        at_max_d = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            cred_d[i] = cred_q[i];
            if (credit_return[i] && !dec_vec[i]) begin
                if (cred_q[i] == CRED_MAX) begin
                    ovf_hit[i] = 1'b1;
                end else begin
                    cred_d[i] = cred_q[i] + CW'(1);
                end
            end else if (dec_vec[i] && !credit_return[i]) begin
                cred_d[i] = cred_q[i] - CW'(1);
            end
            eligible[i] = (cred_d[i] != '0);
            at_max_d[i] = (cred_d[i] == CRED_MAX);
        end
    end

    // Advance the round-robin pointer past the stream that was just granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (select_data == PW'(NUM_STREAMS - 1)) ? '0 : select_data + PW'(1);
        end
    end

    // Pick the first eligible stream at or above the updated pointer, wrapping
    // around. The loop runs downward so that the smallest offset is the last
    // one to write choice.
    always_comb begin
        choice = rr_ptr_d;
        idx    = '0;
        for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr_d) + k) % NUM_STREAMS);
            if (eligible[idx]) begin
                choice = idx;
            end
        end
    end

    // Offer FSM. An offer is held until it completes the handshake, and it is
    // never withdrawn. After a handshake the next choice is loaded at once,
    // which allows back-to-back grants.
    always_comb begin
        state_d = state_q;
        data_d  = select_data;
        case (state_q)
            ST_IDLE: begin
                if (enable && any_elig) begin
                    state_d = ST_OFFER;
                    data_d  = choice;
                end
            end
            ST_OFFER: begin
                if (handshake) begin
                    if (enable && any_elig) begin
                        data_d = choice;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer, credit pool and status flags.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            select_data     <= '0;
            rr_ptr_q        <= '0;
            all_idle        <= 1'b1;
            credit_overflow <= 1'b0;
            // NOTE: the credit array is architectural state, not storage for
            // data, so each entry is reset explicitly to a full pool.
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cred_q[i] <= CRED_MAX;
            end
        end else begin
            state_q         <= state_d;
            select_data     <= data_d;
            rr_ptr_q        <= rr_ptr_d;
            all_idle        <= &at_max_d;
            credit_overflow <= credit_overflow | (|ovf_hit);
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cred_q[i] <= cred_d[i];
            end
        end
    end

    // Flatten the credit pool onto the credits port, with stream 0 in the LSBs.
    always_comb begin
        credits = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            credits[i*CW +: CW] = cred_q[i];
        end
    end

`ifdef STREAM_DISPATCH_STATS_EN
    logic [31:0] disp_cnt [NUM_STREAMS];

    // Per-stream handshake counters. They wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                disp_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (dec_vec[i]) begin
                    disp_cnt[i] <= disp_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Flatten the counters onto dispatch_count, with stream 0 in the LSBs.
    always_comb begin
        dispatch_count = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            dispatch_count[i*32 +: 32] = disp_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_stream_dispatch_scheduler.sv
// Directed testbench for stream_dispatch_scheduler (NUM_STREAMS=4,
// MAX_CREDITS=2). Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, well away from the next active edge.
`timescale 1ns/1ps

module tb_stream_dispatch_scheduler;

    localparam int NS = 4;
    localparam int MC = 2;
    localparam int CW = $clog2(MC + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 select_valid;
    logic                 select_ready;
    logic [1:0]           select_data;
    logic [NS-1:0]        credit_return;
    logic [NS*CW-1:0]     credits;
    logic                 all_idle;
    logic                 credit_overflow;
`ifdef STREAM_DISPATCH_STATS_EN
    logic [NS*32-1:0]     dispatch_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    stream_dispatch_scheduler #(
        .NUM_STREAMS (NS),
        .MAX_CREDITS (MC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .select_valid    (select_valid),
        .select_ready    (select_ready),
        .select_data     (select_data),
        .credit_return   (credit_return),
        .credits         (credits),
        .all_idle        (all_idle),
        .credit_overflow (credit_overflow)
`ifdef STREAM_DISPATCH_STATS_EN
        ,
        .dispatch_count  (dispatch_count)
`endif
    );

    always #5 clk = ~clk;

    // Global time limit, so a stuck run still ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        enable        = 1'b0;
        select_ready  = 1'b0;
        credit_return = '0;
        tick();
        tick();
        n_checks++;
        if (select_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_valid: got %0b want 0", select_valid);
        end
        n_checks++;
        if (select_data !== 2'd0) begin
            n_fails++; $display("FAIL reset_data: got %0d want 0", select_data);
        end
        n_checks++;
        if (credits !== 8'hAA) begin
            n_fails++; $display("FAIL reset_credits: got %h want aa", credits);
        end
        n_checks++;
        if (all_idle !== 1'b1) begin
            n_fails++; $display("FAIL reset_all_idle: got %0b want 1", all_idle);
        end
        n_checks++;
        if (credit_overflow !== 1'b0) begin
            n_fails++; $display("FAIL reset_overflow: got %0b want 0", credit_overflow);
        end
    endtask

    // Two full round-robin laps use up every credit, and then the block idles.
    task automatic test_round_robin_exhaust();
        rst_n        = 1'b1;
        enable       = 1'b1;
        select_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (select_valid !== 1'b1 || select_data !== 2'(i % 4)) begin
                n_fails++;
                $display("FAIL rr_seq[%0d]: got valid=%0b data=%0d want valid=1 data=%0d",
                         i, select_valid, select_data, i % 4);
            end
        end
        tick();
        n_checks++;
        if (select_valid !== 1'b0) begin
            n_fails++; $display("FAIL rr_end_valid: got %0b want 0", select_valid);
        end
        n_checks++;
        if (credits !== 8'h00) begin
            n_fails++; $display("FAIL rr_end_credits: got %h want 00", credits);
        end
        n_checks++;
        if (all_idle !== 1'b0) begin
            n_fails++; $display("FAIL rr_end_all_idle: got %0b want 0", all_idle);
        end
    endtask

    // One returned credit on stream 2 produces exactly one offer of stream 2.
    task automatic test_credit_return();
        credit_return = 4'b0100;
        tick();
        credit_return = '0;
        n_checks++;
        if (select_valid !== 1'b1 || select_data !== 2'd2) begin
            n_fails++;
            $display("FAIL ret_offer: got valid=%0b data=%0d want valid=1 data=2",
                     select_valid, select_data);
        end
        n_checks++;
        if (credits !== 8'h10) begin
            n_fails++; $display("FAIL ret_credits: got %h want 10", credits);
        end
        tick();
        n_checks++;
        if (select_valid !== 1'b0) begin
            n_fails++; $display("FAIL ret_after_valid: got %0b want 0", select_valid);
        end
        n_checks++;
        if (credits !== 8'h00) begin
            n_fails++; $display("FAIL ret_after_credits: got %h want 00", credits);
        end
    endtask

    // While ready is held low, the offer stays fixed even when enable toggles.
    task automatic test_ready_stall();
        select_ready  = 1'b0;
        credit_return = 4'b1111;
        tick();
        credit_return = '0;
        n_checks++;
        if (select_valid !== 1'b1 || select_data !== 2'd3) begin
            n_fails++;
            $display("FAIL stall_first: got valid=%0b data=%0d want valid=1 data=3",
                     select_valid, select_data);
        end
        for (int c = 0; c < 5; c++) begin
            enable = (c % 2 == 1);
            tick();
            n_checks++;
            if (select_valid !== 1'b1 || select_data !== 2'd3) begin
                n_fails++;
                $display("FAIL stall_hold[%0d]: got valid=%0b data=%0d want valid=1 data=3",
                         c, select_valid, select_data);
            end
        end
        select_ready = 1'b1;
        enable       = 1'b0;
        tick();
        n_checks++;
        if (select_valid !== 1'b0) begin
            n_fails++; $display("FAIL stall_done_valid: got %0b want 0", select_valid);
        end
        n_checks++;
        if (credits !== 8'h15) begin
            n_fails++; $display("FAIL stall_done_credits: got %h want 15", credits);
        end
        tick();
        n_checks++;
        if (select_valid !== 1'b0) begin
            n_fails++; $display("FAIL stall_idle_valid: got %0b want 0", select_valid);
        end
    endtask

    // A dispatch and a return on stream 1 in the same cycle cancel out. The
    // next offer then shows that the pointer has moved on to stream 2.
    task automatic test_same_cycle_dispatch_return();
        enable       = 1'b1;
        select_ready = 1'b1;
        tick();
        n_checks++;
        if (select_valid !== 1'b1 || select_data !== 2'd0) begin
            n_fails++;
            $display("FAIL same_first: got valid=%0b data=%0d want valid=1 data=0",
                     select_valid, select_data);
        end
        tick();
        n_checks++;
        if (select_valid !== 1'b1 || select_data !== 2'd1) begin
            n_fails++;
            $display("FAIL same_b2b: got valid=%0b data=%0d want valid=1 data=1",
                     select_valid, select_data);
        end
        n_checks++;
        if (credits !== 8'h14) begin
            n_fails++; $display("FAIL same_pre_credits: got %h want 14", credits);
        end
        credit_return = 4'b0010;
        enable        = 1'b0;
        tick();
        credit_return = '0;
        n_checks++;
        if (credits !== 8'h14) begin
            n_fails++; $display("FAIL same_net_zero: got %h want 14", credits);
        end
        n_checks++;
        if (select_valid !== 1'b0) begin
            n_fails++; $display("FAIL same_idle: got %0b want 0", select_valid);
        end
        enable       = 1'b1;
        select_ready = 1'b0;
        tick();
        n_checks++;
        if (select_valid !== 1'b1 || select_data !== 2'd2) begin
            n_fails++;
            $display("FAIL same_rr_ptr: got valid=%0b data=%0d want valid=1 data=2",
                     select_valid, select_data);
        end
        select_ready = 1'b1;
        enable       = 1'b0;
        tick();
        n_checks++;
        if (credits !== 8'h04) begin
            n_fails++; $display("FAIL same_end_credits: got %h want 04", credits);
        end
        n_checks++;
        if (credit_overflow !== 1'b0) begin
            n_fails++; $display("FAIL same_no_overflow: got %0b want 0", credit_overflow);
        end
    endtask

    // Reset during an offer drops the offer. A return to a full stream then
    // sets the sticky overflow flag, which only a reset clears.
    task automatic test_overflow();
        enable       = 1'b1;
        select_ready = 1'b0;
        tick();
        n_checks++;
        if (select_valid !== 1'b1 || select_data !== 2'd1) begin
            n_fails++;
            $display("FAIL mid_offer: got valid=%0b data=%0d want valid=1 data=1",
                     select_valid, select_data);
        end
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        n_checks++;
        if (select_valid !== 1'b0 || select_data !== 2'd0) begin
            n_fails++;
            $display("FAIL mid_reset: got valid=%0b data=%0d want valid=0 data=0",
                     select_valid, select_data);
        end
        n_checks++;
        if (credits !== 8'hAA) begin
            n_fails++; $display("FAIL mid_reset_credits: got %h want aa", credits);
        end
        rst_n         = 1'b1;
        credit_return = 4'b0001;
        tick();
        credit_return = '0;
        n_checks++;
        if (credits !== 8'hAA) begin
            n_fails++; $display("FAIL ovf_saturate: got %h want aa", credits);
        end
        n_checks++;
        if (credit_overflow !== 1'b1) begin
            n_fails++; $display("FAIL ovf_set: got %0b want 1", credit_overflow);
        end
        n_checks++;
        if (all_idle !== 1'b1) begin
            n_fails++; $display("FAIL ovf_all_idle: got %0b want 1", all_idle);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (credit_overflow !== 1'b1) begin
            n_fails++; $display("FAIL ovf_sticky: got %0b want 1", credit_overflow);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (credit_overflow !== 1'b0) begin
            n_fails++; $display("FAIL ovf_cleared: got %0b want 0", credit_overflow);
        end
        rst_n = 1'b1;
    endtask

`ifdef STREAM_DISPATCH_STATS_EN
    // Ten handshakes in round-robin order, with each granted credit returned at
    // once so that credits never run out.
    task automatic test_stats();
        logic [31:0] exp_cnt [NS];
        exp_cnt[0] = 32'd3;
        exp_cnt[1] = 32'd3;
        exp_cnt[2] = 32'd2;
        exp_cnt[3] = 32'd2;
        rst_n         = 1'b0;
        enable        = 1'b0;
        select_ready  = 1'b0;
        credit_return = '0;
        tick();
        rst_n        = 1'b1;
        enable       = 1'b1;
        select_ready = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            credit_return = 4'b0001 << select_data;
            tick();
        end
        select_ready  = 1'b0;
        enable        = 1'b0;
        credit_return = '0;
        for (int i = 0; i < NS; i++) begin
            n_checks++;
            if (dispatch_count[i*32 +: 32] !== exp_cnt[i]) begin
                n_fails++;
                $display("FAIL stats_count[%0d]: got %0d want %0d",
                         i, dispatch_count[i*32 +: 32], exp_cnt[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin_exhaust();
        test_credit_return();
        test_ready_stall();
        test_same_cycle_dispatch_return();
        test_overflow();
`ifdef STREAM_DISPATCH_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
